// File: rtl/piso_rr_ctrl.sv
// rtl/piso_rr_ctrl.sv - round-robin shared PISO serialiser, framed LSB-first output
// Optional build macro: PISO_RR_B2B_EN (back-to-back frames, accept window reopens on the last bit)
module piso_rr_ctrl #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = $clog2(WIDTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    serial_out,
  output logic                    serial_valid,
  output logic                    frame_start,
  output logic                    frame_end,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
);

`ifdef PISO_RR_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    bit_cnt, bit_cnt_nx;
  logic [WIDTH-1:0] shift_reg, shift_nx;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    win_id;
  logic [WIDTH-1:0] win_data;
  logic             win_found;
  logic             accept_open;
  logic             handshake;

  // Window is open in IDLE, and on the last bit of a frame when back-to-back is built in
  assign accept_open = !reset &&
                       ((state == IDLE) || (B2B && (state == SHIFT) && (bit_cnt == LAST)));
  assign handshake   = accept_open && win_found;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    win_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = GW'(idx);
        win_data  = req_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next state, bit counter and shift register load
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift_reg;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nx   = SHIFT;
          bit_cnt_nx = '0;
          shift_nx   = win_data;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST) begin
          bit_cnt_nx = '0;
          if (handshake) begin
            state_nx = SHIFT;
            shift_nx = win_data;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          bit_cnt_nx = bit_cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: one-hot grant only while the window is open and someone is valid
  always_comb begin
    req_ready = '0;
    if (handshake) req_ready = NREQ'(1) << win_id;
  end

  // Datapath state: counter, word, pointer and grant advance on handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      rr_ptr    <= '0;
      grant_id  <= '0;
    end else begin
      bit_cnt   <= bit_cnt_nx;
      shift_reg <= shift_nx;
      if (handshake) begin
        grant_id <= win_id;
        rr_ptr   <= (win_id == GW'(NREQ - 1)) ? '0 : win_id + GW'(1);
      end
    end
  end

  // Line outputs are registered from next-cycle values so all strobes describe one bit slot
  always_ff @(posedge clock) begin
    if (reset) begin
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      busy         <= 1'b0;
    end else if (state_nx == SHIFT) begin
      serial_out   <= shift_nx[bit_cnt_nx];
      serial_valid <= 1'b1;
      frame_start  <= (bit_cnt_nx == '0);
      frame_end    <= (bit_cnt_nx == LAST);
      busy         <= 1'b1;
    end else begin
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      busy         <= 1'b0;
    end
  end

endmodule
